// File: rtl/param_reg_file.sv
// param_reg_file: parametrised register file with two asynchronous read
// ports, two synchronous write ports and a built-in clear sequencer that
// zeroes every entry after reset or on a clr request. The storage array has
// no per-entry reset so it can map onto distributed RAM.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data
// to the read ports; undefined (default) reads return pre-edge array contents.
module param_reg_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  output logic              ready,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic              we2,
  input  logic [ADDR_W-1:0] wa2,
  input  logic [DATA_W-1:0] wd2,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam bit ZR    = (ZERO_REG != 0);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W:0]   cptr_q, cptr_d;
  logic [ADDR_W:0]   cptr_inc_s;
  logic              ready_s;
  logic              wen1_s, wen2_s;
  logic [DATA_W-1:0] mem_q [DEPTH];

  // The clear pointer carries one extra bit; its MSB setting marks the end of the sweep.
  assign cptr_inc_s = cptr_q + {{ADDR_W{1'b0}}, 1'b1};
  assign ready_s    = (state_q == S_READY);
  assign ready      = ready_s;

  // Next-state logic for the clear sequencer; clr always restarts the sweep at entry 0.
  always_comb begin
    state_d = state_q;
    cptr_d  = cptr_q;
    case (state_q)
      S_CLEAR: begin
        if (clr) begin
          cptr_d = '0;
        end else if (cptr_inc_s[ADDR_W]) begin
          state_d = S_READY;
          cptr_d  = cptr_inc_s;
        end else begin
          cptr_d  = cptr_inc_s;
        end
      end
      S_READY: begin
        if (clr) begin
          state_d = S_CLEAR;
          cptr_d  = '0;
        end else begin
          state_d = S_READY;
        end
      end
      default: begin
        state_d = S_CLEAR;
        cptr_d  = '0;
      end
    endcase
  end

  // Sequencer state; reset forces a fresh clear sweep from entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_CLEAR;
      cptr_q  <= '0;
    end else begin
      state_q <= state_d;
      cptr_q  <= cptr_d;
    end
  end

  // Write qualification: port 2 wins a same-address collision, entry 0 is read-only zero when ZR.
  always_comb begin
    wen1_s = 1'b0;
    wen2_s = 1'b0;
    if (ready_s) begin
      wen1_s = we1 && !(ZR && (wa1 == '0)) && !(we2 && (wa2 == wa1));
      wen2_s = we2 && !(ZR && (wa2 == '0));
    end else begin
      wen1_s = 1'b0;
      wen2_s = 1'b0;
    end
  end

  // Storage array, no reset: the sweep zeroes one entry per cycle, otherwise the write ports commit.
  always_ff @(posedge clk) begin
    if (state_q == S_CLEAR) begin
      mem_q[cptr_q[ADDR_W-1:0]] <= '0;
    end else begin
      if (wen1_s) mem_q[wa1] <= wd1;
      if (wen2_s) mem_q[wa2] <= wd2;
    end
  end

  // Read port 1: zero while clearing or for the hard-wired zero entry.
  always_comb begin
    rd1 = '0;
    if (ready_s && !(ZR && (ra1 == '0))) begin
`ifdef REGFILE_BYPASS_EN
      if (we2 && (wa2 == ra1)) begin
        rd1 = wd2;
      end else if (we1 && (wa1 == ra1)) begin
        rd1 = wd1;
      end else begin
        rd1 = mem_q[ra1];
      end
`else
      rd1 = mem_q[ra1];
`endif
    end else begin
      rd1 = '0;
    end
  end

  // Read port 2: same rules as port 1.
  always_comb begin
    rd2 = '0;
    if (ready_s && !(ZR && (ra2 == '0))) begin
`ifdef REGFILE_BYPASS_EN
      if (we2 && (wa2 == ra2)) begin
        rd2 = wd2;
      end else if (we1 && (wa1 == ra2)) begin
        rd2 = wd1;
      end else begin
        rd2 = mem_q[ra2];
      end
`else
      rd2 = mem_q[ra2];
`endif
    end else begin
      rd2 = '0;
    end
  end

endmodule
